// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, halt word default and
// the IF/ID field widths that the decode stage also relies on.
package fetch_pkg;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_t;

    localparam int IFID_ADDR_W = 8;
    localparam int IFID_DATA_W = 32;

    localparam logic [IFID_DATA_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Loads a freshly fetched word, holds it while decode
// is stalled, or turns into a bubble (valid cleared, payload kept).
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_W = IFID_ADDR_W,
    parameter int DATA_W = IFID_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  logic [DATA_W-1:0] next_instruction,
    input  logic [ADDR_W-1:0] next_pc,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] pc,
    output logic              valid
);

    // Bubble wins over load so a redirect never lets a stale word through.
    always_ff @(posedge clk) begin
        if (rst) begin
            instruction <= '0;
            pc          <= '0;
            valid       <= 1'b0;
        end else if (bubble) begin
            valid       <= 1'b0;
        end else if (load) begin
            instruction <= next_instruction;
            pc          <= next_pc;
            valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory address, captures
// the returned word into IF/ID and handles stall, branch redirect and halt.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = IFID_ADDR_W,
    parameter int                DATA_W    = IFID_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = 8'h00,
    parameter logic [DATA_W-1:0] HALT_WORD = HALT_WORD_DEFAULT,
    parameter int                CNT_W     = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Stall,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    output logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] InstructionIn,
    output logic [DATA_W-1:0] InstructionOut,
    output logic [ADDR_W-1:0] PCOut,
    output logic              ValidOut,
    output logic              Halted,
    output logic [CNT_W-1:0]  FetchCount
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  count;
    logic              capture;
    logic              halt_seen;
    logic              bubble;

    // A normal capture only happens while running with no redirect or stall;
    // InstructionIn is looked at nowhere else, so an X from memory stays contained.
    assign capture   = (state == FS_RUN) && !BranchTaken && !Stall;
    assign halt_seen = capture && (InstructionIn == HALT_WORD);
    assign bubble    = ((state == FS_RUN) && BranchTaken) || (state == FS_HALT);

    assign Address    = pc;
    assign Halted     = (state == FS_HALT);
    assign FetchCount = count;

    // PC update and RUN/HALT state; the halt word freezes the PC at its own address.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= FS_RUN;
            pc    <= RESET_PC;
        end else begin
            case (state)
                FS_RUN: begin
                    if (BranchTaken) begin
                        pc <= BranchTarget;
                    end else if (!Stall) begin
                        if (halt_seen) begin
                            state <= FS_HALT;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                FS_HALT: begin
                    pc <= pc;
                end
                default: begin
                    state <= FS_HALT;
                end
            endcase
        end
    end

    // Saturating count of words handed to decode with valid set.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            count <= '0;
        end else if (capture && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    ifid_reg #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ifid (
        .clk              (Clk),
        .rst              (Rst),
        .load             (capture),
        .bubble           (bubble),
        .next_instruction (InstructionIn),
        .next_pc          (pc),
        .instruction      (InstructionOut),
        .pc               (PCOut),
        .valid            (ValidOut)
    );

endmodule
